spike_event_sequencer: RTL and testbench

SPIKE_EVENT_SEQUENCER -- requirements
Module: spike_event_sequencer

---
 rtl/spike_event_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_spike_event_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_sequencer.sv
// Spike event sequencer: timestamped event FIFO replayed
// onto per-row synapse stimulus strobes against a run-time counter.
module spike_event_sequencer #(
   parameter int NUM_SYNAPSE_ROWS = 1,
   parameter int ADDR_W           = 6,
   parameter int TIME_W           = 16,
   parameter int DEPTH            = 16,
   localparam int ROW_W =
      (NUM_SYNAPSE_ROWS > 1) ? $clog2(NUM_SYNAPSE_ROWS) : 1
) (
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               start,
   input  logic                               stop,
   input  logic                               flush,
   input  logic                               ev_valid,
   output logic                               ev_ready,
   input  logic [TIME_W-1:0]                  ev_time,
   input  logic [ROW_W-1:0]                   ev_row,
   input  logic [ADDR_W-1:0]                  ev_addr,
   input  logic                               ev_on_off,
   output logic [NUM_SYNAPSE_ROWS-1:0]        stim_valid,
   output logic [NUM_SYNAPSE_ROWS*ADDR_W-1:0] stim_addr,
   output logic [NUM_SYNAPSE_ROWS-1:0]        stim_on_off,
   output logic [TIME_W-1:0]                  time_now,
   output logic                               busy,
   output logic [7:0]                         late_count,
   output logic                               row_error
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);
   localparam logic [TIME_W-1:0] T_MAX = '1;

   typedef enum logic {
      S_IDLE,
      S_RUN
   } state_t;

   state_t r_state;
   state_t w_state_nxt;
   logic   w_time_clr;

   logic [TIME_W-1:0] r_time;

   logic [TIME_W-1:0] r_mem_time [DEPTH];
   logic [ROW_W-1:0]  r_mem_row  [DEPTH];
   logic [ADDR_W-1:0] r_mem_addr [DEPTH];
   logic              r_mem_on   [DEPTH];

   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [PTR_W:0]   r_count;

   logic [NUM_SYNAPSE_ROWS-1:0]        r_stim_valid;
   logic [NUM_SYNAPSE_ROWS*ADDR_W-1:0] r_stim_addr;
   logic [NUM_SYNAPSE_ROWS-1:0]        r_stim_on;
   logic [7:0]                         r_late;
   logic                               r_row_err;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_late;
   logic              w_row_ok;
   logic              w_fire;
   logic [TIME_W-1:0] w_head_time;
   logic [ROW_W-1:0]  w_head_row;
   logic [ADDR_W-1:0] w_head_addr;
   logic              w_head_on;

   assign w_full      = (r_count == CNT_FULL);
   assign w_empty     = (r_count == '0);
   assign w_head_time = r_mem_time[r_rd_ptr];
   assign w_head_row  = r_mem_row[r_rd_ptr];
   assign w_head_addr = r_mem_addr[r_rd_ptr];
   assign w_head_on   = r_mem_on[r_rd_ptr];

   // Flush wins over both load and release in the same cycle.
   assign w_push   = ev_valid && !w_full && !flush;
   assign w_pop    = (r_state == S_RUN) && !w_empty && !flush
                     && (w_head_time <= r_time);
   assign w_late   = w_pop && (w_head_time < r_time);
   assign w_row_ok = (int'(w_head_row) < NUM_SYNAPSE_ROWS);
   assign w_fire   = w_pop && w_row_ok;

   // Held low during reset so no loads are taken before release.
   assign ev_ready    = reset_n && !w_full;
   assign busy        = (r_state == S_RUN);
   assign time_now    = r_time;
   assign stim_valid  = r_stim_valid;
   assign stim_addr   = r_stim_addr;
   assign stim_on_off = r_stim_on;
   assign late_count  = r_late;
   assign row_error   = r_row_err;

   // Playback state register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state; stop dominates start, start ignored in RUN.
   always_comb begin
      w_state_nxt = r_state;
      w_time_clr  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_state_nxt = S_RUN;
               w_time_clr  = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Saturating playback time, frozen outside RUN.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_time <= '0;
      end else if (w_time_clr) begin
         r_time <= '0;
      end else if (r_state == S_RUN && !stop && r_time != T_MAX) begin
         r_time <= r_time + 1'b1;
      end
   end

   // Event storage; occupancy tracked by the pointer logic.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_time[r_wr_ptr] <= ev_time;
         r_mem_row[r_wr_ptr]  <= ev_row;
         r_mem_addr[r_wr_ptr] <= ev_addr;
         r_mem_on[r_wr_ptr]   <= ev_on_off;
      end
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // One-cycle row strobe; address and flag hold between strobes.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stim_valid <= '0;
         r_stim_addr  <= '0;
         r_stim_on    <= '0;
      end else begin
         for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
            r_stim_valid[r] <= w_fire && (w_head_row == ROW_W'(r));
            if (w_fire && (w_head_row == ROW_W'(r))) begin
               r_stim_addr[r*ADDR_W +: ADDR_W] <= w_head_addr;
               r_stim_on[r] <= w_head_on;
            end
         end
      end
   end

   // Late-release counter and sticky bad-row flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_late    <= '0;
         r_row_err <= 1'b0;
      end else begin
         if (w_late && r_late != 8'hFF) begin
            r_late <= r_late + 1'b1;
         end
         if (w_pop && !w_row_ok) begin
            r_row_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_spike_event_sequencer.sv
// Bench for spike_event_sequencer: scoreboard of expected
// strobes (row, addr, flag, time) checked by a strobe monitor.
module tb_spike_event_sequencer;

   localparam int N  = 3;
   localparam int AW = 6;
   localparam int TW = 16;
   localparam int D  = 16;
   localparam int RW = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic            flush = 1'b0;
   logic            ev_valid = 1'b0;
   logic            ev_ready;
   logic [TW-1:0]   ev_time = '0;
   logic [RW-1:0]   ev_row = '0;
   logic [AW-1:0]   ev_addr = '0;
   logic            ev_on_off = 1'b0;
   logic [N-1:0]    stim_valid;
   logic [N*AW-1:0] stim_addr;
   logic [N-1:0]    stim_on_off;
   logic [TW-1:0]   time_now;
   logic            busy;
   logic [7:0]      late_count;
   logic            row_error;

   spike_event_sequencer #(
      .NUM_SYNAPSE_ROWS(N),
      .ADDR_W(AW),
      .TIME_W(TW),
      .DEPTH(D)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .start(start),
      .stop(stop),
      .flush(flush),
      .ev_valid(ev_valid),
      .ev_ready(ev_ready),
      .ev_time(ev_time),
      .ev_row(ev_row),
      .ev_addr(ev_addr),
      .ev_on_off(ev_on_off),
      .stim_valid(stim_valid),
      .stim_addr(stim_addr),
      .stim_on_off(stim_on_off),
      .time_now(time_now),
      .busy(busy),
      .late_count(late_count),
      .row_error(row_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      int row;
      int addr;
      int on;
      int t;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;
   int   n_tests = 0;
   int   n_fail = 0;
   int   prev_pop = -1;
   int   exp_late = 0;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Strobe monitor: every strobe must match the scoreboard head.
   always @(posedge clk) begin
      #1;
      for (int r = 0; r < N; r++) begin
         if (stim_valid[r]) begin
            if (sbq.size() == 0) begin
               check("unexpected_strobe_row", 32'(r), 32'hFFFF);
            end else begin
               mon_e = sbq.pop_front();
               check("strobe_row", 32'(r), 32'(mon_e.row));
               check("strobe_addr", 32'(stim_addr[r*AW +: AW]),
                     32'(mon_e.addr));
               check("strobe_on", 32'(stim_on_off[r]),
                     32'(mon_e.on));
               check("strobe_time", 32'(time_now), 32'(mon_e.t));
            end
         end
      end
   end

   task automatic push_exp(input int t, input int row,
                           input int addr, input int on);
      int p;
      p = (t > prev_pop) ? t : prev_pop + 1;
      prev_pop = p;
      if (p > t) exp_late++;
      if (row < N) sbq.push_back('{row, addr, on, p + 1});
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
      flush    = 1'b0;
      ev_valid = 1'b0;
      cyc(2);
      reset_n  = 1'b1;
      sbq.delete();
      prev_pop = -1;
      exp_late = 0;
   endtask

   task automatic load(input int t, input int row, input int addr,
                       input int on, input bit track);
      int k;
      k = 0;
      while (!ev_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (!ev_ready) check("load_ready_timeout", 32'(ev_ready), 32'd1);
      ev_valid  = 1'b1;
      ev_time   = TW'(t);
      ev_row    = RW'(row);
      ev_addr   = AW'(addr);
      ev_on_off = on[0];
      @(negedge clk);
      ev_valid  = 1'b0;
      if (track) push_exp(t, row, addr, on);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic wait_drain(input int max);
      int k;
      k = 0;
      while (sbq.size() != 0 && k < max) begin
         @(negedge clk);
         k++;
      end
      check("drain_left", 32'(sbq.size()), 32'd0);
   endtask

   task automatic wait_time(input int tv, input int max);
      int k;
      k = 0;
      while (int'(time_now) != tv && k < max) begin
         @(posedge clk);
         #1;
         k++;
      end
      check("time_reach", 32'(time_now), 32'(tv));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit hit");
      $fatal(1);
   end

   initial begin
      int a;

      // Reset state while reset_n is held low
      #2;
      check("rst_ev_ready", 32'(ev_ready), 32'd0);
      check("rst_stim_valid", 32'(stim_valid), 32'd0);
      check("rst_stim_addr", 32'(stim_addr), 32'd0);
      check("rst_time", 32'(time_now), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_late", 32'(late_count), 32'd0);
      check("rst_row_err", 32'(row_error), 32'd0);
      cyc(2);
      reset_n = 1'b1;
      #1;
      check("rst_rel_ready", 32'(ev_ready), 32'd1);
      @(negedge clk);

      // Single on-time event
      load(5, 0, 3, 1, 1);
      pulse_start();
      check("run_busy", 32'(busy), 32'd1);
      wait_drain(40);
      check("single_late", 32'(late_count), 32'(exp_late));
      a = int'(time_now);
      pulse_start();
      check("start_in_run_ignored", 32'(time_now), 32'(a + 1));

      // Equal timestamps over two rows
      do_reset();
      load(2, 0, 10, 1, 1);
      load(2, 1, 11, 0, 1);
      load(2, 0, 12, 1, 1);
      pulse_start();
      wait_drain(40);
      check("equal_ts_late", 32'(late_count), 32'd2);

      // Out-of-range row is dropped and flagged
      do_reset();
      load(1, 3, 5, 1, 1);
      load(3, 1, 7, 1, 1);
      check("row_err_before", 32'(row_error), 32'd0);
      pulse_start();
      wait_drain(40);
      check("row_err_set", 32'(row_error), 32'd1);
      cyc(5);
      check("row_err_sticky", 32'(row_error), 32'd1);
      check("row_err_late", 32'(late_count), 32'(exp_late));

      // Full FIFO backpressure and recovery
      do_reset();
      for (int i = 0; i < D; i++) load(20, i % N, i, i % 2, 1);
      check("full_not_ready", 32'(ev_ready), 32'd0);
      pulse_start();
      wait_time(20, 60);
      @(posedge clk);
      #1;
      check("ready_after_pop", 32'(ev_ready), 32'd1);
      @(negedge clk);
      load(40, 2, 33, 1, 1);
      wait_drain(80);
      check("full_late", 32'(late_count), 32'(exp_late));

      // Stop holds time; restart counts from zero
      do_reset();
      load(10, 2, 9, 0, 0);
      pulse_start();
      wait_time(4, 20);
      @(negedge clk);
      pulse_stop();
      check("stop_time_hold", 32'(time_now), 32'd4);
      check("stop_idle", 32'(busy), 32'd0);
      cyc(3);
      check("idle_time_frozen", 32'(time_now), 32'd4);
      push_exp(10, 2, 9, 0);
      pulse_start();
      check("restart_time", 32'(time_now), 32'd0);
      wait_drain(40);
      check("restart_late", 32'(late_count), 32'd0);

      // Reset in the middle of playback
      do_reset();
      for (int i = 0; i < 4; i++) load(3, i % N, i, 1, 0);
      pulse_start();
      wait_time(2, 20);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_stim", 32'(stim_valid), 32'd0);
      check("mid_rst_time", 32'(time_now), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_ready", 32'(ev_ready), 32'd0);
      @(negedge clk);
      cyc(1);
      reset_n = 1'b1;
      #1;
      check("post_rst_ready", 32'(ev_ready), 32'd1);
      @(negedge clk);
      pulse_start();
      cyc(20);
      check("post_rst_late", 32'(late_count), 32'd0);

      // Flush discards queue and rejects a same-cycle load
      do_reset();
      load(0, 0, 1, 1, 0);
      load(1, 1, 2, 1, 0);
      ev_valid = 1'b1;
      ev_time  = TW'(2);
      ev_row   = RW'(2);
      flush    = 1'b1;
      @(negedge clk);
      flush    = 1'b0;
      ev_valid = 1'b0;
      check("flush_ready", 32'(ev_ready), 32'd1);
      pulse_start();
      cyc(10);
      check("flush_time", 32'(time_now), 32'd10);
      check("flush_busy", 32'(busy), 32'd1);
      check("flush_late", 32'(late_count), 32'd0);

      cyc(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
